// File: rtl/mem_access_seq.sv
// mem_access_seq: sequences one CPU request into active-low SRAM strobes with programmable wait states
module mem_access_seq #(
  parameter int READ_WAIT  = 2,
  parameter int WRITE_WAIT = 2,
  parameter int TURNAROUND = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req,
  input  logic        Rw,
  input  logic [19:0] Addr,
  input  logic [15:0] Wdata,
  input  logic [1:0]  Bmask,
  output logic        Ready,
  output logic        Ack,
  output logic [15:0] Rdata,
  output logic [19:0] ADDR,
  output logic        CE,
  output logic        UB,
  output logic        LB,
  output logic        OE,
  output logic        WE,
  output logic [15:0] Data_to_mem,
  input  logic [15:0] Data_from_mem
);
  typedef enum logic [2:0] {IDLE, RD_STROBE, WR_SETUP, WR_PULSE, WR_HOLD, ACK, TURN} state_e;
  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d, ld;
  logic [19:0] addr_q, addr_d;
  logic [15:0] dout_q, dout_d, rdata_q, rdata_d;
  logic ce_q, ce_d, ub_q, ub_d, lb_q, lb_d, oe_q, oe_d, we_q, we_d, ack_q, ack_d;
  logic last, acc_d, wr_d, fresh;
  always_comb begin
    last = cnt_q == 4'd1;
    fresh = state_q == IDLE;
    state_d = state_q == IDLE      ? (Req ? (Bmask == 2'b00 ? ACK : Rw ? WR_SETUP : RD_STROBE) : IDLE)
            : state_q == RD_STROBE ? (last ? ACK : RD_STROBE)
            : state_q == WR_SETUP  ? WR_PULSE
            : state_q == WR_PULSE  ? (last ? WR_HOLD : WR_PULSE)
            : state_q == WR_HOLD   ? ACK
            : state_q == ACK       ? (TURNAROUND == 0 ? IDLE : TURN)
            : state_q == TURN      ? (last ? IDLE : TURN)
            : IDLE;
    ld = state_d == RD_STROBE ? 4'(READ_WAIT)
       : state_d == WR_PULSE  ? 4'(WRITE_WAIT)
       : state_d == TURN      ? 4'(TURNAROUND)
       : 4'd0;
    cnt_d = state_d != state_q ? ld : cnt_q - {3'b000, |cnt_q};
    acc_d = state_d inside {RD_STROBE, WR_SETUP, WR_PULSE, WR_HOLD};
    wr_d = state_d inside {WR_SETUP, WR_PULSE, WR_HOLD};
    addr_d = acc_d ? (fresh ? Addr : addr_q) : 20'd0;
    ub_d = acc_d ? (fresh ? ~Bmask[1] : ub_q) : 1'b1;
    lb_d = acc_d ? (fresh ? ~Bmask[0] : lb_q) : 1'b1;
    ce_d = ~acc_d;
    oe_d = state_d != RD_STROBE;
    we_d = state_d != WR_PULSE;
    dout_d = wr_d ? (fresh ? Wdata : dout_q) : 16'd0;
    ack_d = state_d == ACK;
    rdata_d = (state_q == RD_STROBE && last) ? Data_from_mem & {{8{~ub_q}}, {8{~lb_q}}} : rdata_q;
  end
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= IDLE;
      cnt_q <= 4'd0;
      addr_q <= 20'd0;
      dout_q <= 16'd0;
      rdata_q <= 16'd0;
      ce_q <= 1'b1;
      ub_q <= 1'b1;
      lb_q <= 1'b1;
      oe_q <= 1'b1;
      we_q <= 1'b1;
      ack_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      dout_q <= dout_d;
      rdata_q <= rdata_d;
      ce_q <= ce_d;
      ub_q <= ub_d;
      lb_q <= lb_d;
      oe_q <= oe_d;
      we_q <= we_d;
      ack_q <= ack_d;
    end
  end
  assign Ready = state_q == IDLE;
  assign Ack = ack_q;
  assign Rdata = rdata_q;
  assign ADDR = addr_q;
  assign CE = ce_q;
  assign UB = ub_q;
  assign LB = lb_q;
  assign OE = oe_q;
  assign WE = we_q;
  assign Data_to_mem = dout_q;
endmodule

// File: tb/tb_mem_access_seq.sv
// tb_mem_access_seq: cycle model check of two parameterisations plus directed latency/data expectations
module tb_mem_access_seq;
  logic Clk = 0, Reset = 0, Req = 0, Rw = 0;
  logic [19:0] Addr = 0;
  logic [15:0] Wdata = 0, Dfm = 0;
  logic [1:0] Bmask = 0;
  logic [1:0] rdy, ack, ce, ub, lb, oe, we;
  logic [1:0][15:0] rd, dtm;
  logic [1:0][19:0] ad;
  int checks = 0, failures = 0;
  int pr[2] = '{2, 1}, pw[2] = '{2, 1}, pt[2] = '{1, 0};
  bit busy[2], mrw[2], armed = 0, cnt_en = 0;
  int k[2];
  logic [19:0] maddr[2];
  logic [15:0] mwd[2], mrd[2];
  logic [1:0] mm[2];
  int nacc = 0, nack = 0;
  int a0, a1, r0, r1;

  mem_access_seq #(.READ_WAIT(2), .WRITE_WAIT(2), .TURNAROUND(1)) dut0 (
    .Clk(Clk), .Reset(Reset), .Req(Req), .Rw(Rw), .Addr(Addr), .Wdata(Wdata), .Bmask(Bmask),
    .Ready(rdy[0]), .Ack(ack[0]), .Rdata(rd[0]), .ADDR(ad[0]), .CE(ce[0]), .UB(ub[0]), .LB(lb[0]),
    .OE(oe[0]), .WE(we[0]), .Data_to_mem(dtm[0]), .Data_from_mem(Dfm));
  mem_access_seq #(.READ_WAIT(1), .WRITE_WAIT(1), .TURNAROUND(0)) dut1 (
    .Clk(Clk), .Reset(Reset), .Req(Req), .Rw(Rw), .Addr(Addr), .Wdata(Wdata), .Bmask(Bmask),
    .Ready(rdy[1]), .Ack(ack[1]), .Rdata(rd[1]), .ADDR(ad[1]), .CE(ce[1]), .UB(ub[1]), .LB(lb[1]),
    .OE(oe[1]), .WE(we[1]), .Data_to_mem(dtm[1]), .Data_from_mem(Dfm));

  always #5 Clk = ~Clk;

  task automatic chk(input string n, input int i, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s dut%0d got=%0h exp=%0h", n, i, got, exp);
    end
  endtask

  function automatic int ack_cyc(input int i);
    return mm[i] == 2'b00 ? 1 : mrw[i] ? pw[i] + 3 : pr[i] + 1;
  endfunction

  always @(posedge Clk) begin
    if (!Reset) begin
      armed = 1;
      for (int i = 0; i < 2; i++) begin
        busy[i] = 0;
        mrd[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (busy[i]) begin
          if (!mrw[i] && mm[i] != 2'b00 && k[i] == pr[i]) mrd[i] = Dfm & {{8{mm[i][1]}}, {8{mm[i][0]}}};
          if (k[i] == ack_cyc(i) + pt[i]) busy[i] = 0;
          else k[i]++;
        end else if (Req) begin
          busy[i] = 1;
          k[i] = 1;
          mrw[i] = Rw;
          maddr[i] = Addr;
          mwd[i] = Wdata;
          mm[i] = Bmask;
        end
      end
    end
  end

  always @(negedge Clk) begin
    if (cnt_en) begin
      if (rdy[0] && Req) nacc++;
      if (ack[0]) nack++;
    end
    if (armed) begin
      for (int i = 0; i < 2; i++) begin
        bit acc, pulse;
        acc = busy[i] && mm[i] != 2'b00 && k[i] >= 1 && k[i] <= (mrw[i] ? pw[i] + 2 : pr[i]);
        pulse = acc && mrw[i] && k[i] >= 2 && k[i] <= pw[i] + 1;
        chk("ready", i, 32'(rdy[i]), 32'(!busy[i]));
        chk("ack", i, 32'(ack[i]), 32'(busy[i] && k[i] == ack_cyc(i)));
        chk("rdata", i, 32'(rd[i]), 32'(mrd[i]));
        chk("addr", i, 32'(ad[i]), acc ? 32'(maddr[i]) : 32'd0);
        chk("ce", i, 32'(ce[i]), 32'(!acc));
        chk("oe", i, 32'(oe[i]), 32'(!(acc && !mrw[i])));
        chk("we", i, 32'(we[i]), 32'(!pulse));
        chk("ub", i, 32'(ub[i]), acc ? 32'(!mm[i][1]) : 32'd1);
        chk("lb", i, 32'(lb[i]), acc ? 32'(!mm[i][0]) : 32'd1);
        chk("dtm", i, 32'(dtm[i]), (acc && mrw[i]) ? 32'(mwd[i]) : 32'd0);
        chk("oe_we_excl", i, 32'(!oe[i] && !we[i]), 32'd0);
      end
    end
  end

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic go(input bit rw, input logic [19:0] a, input logic [15:0] wd, input logic [1:0] m);
    Req = 1; Rw = rw; Addr = a; Wdata = wd; Bmask = m;
    tick;
    Req = 0; Addr = 20'($urandom); Wdata = 16'($urandom); Bmask = 2'($urandom);
    a0 = 0; a1 = 0; r0 = 0; r1 = 0;
    for (int c = 1; c <= 40 && r0 == 0; c++) begin
      if (ack[1] && a1 == 0) a1 = c;
      if (rdy[1] && r1 == 0) r1 = c;
      if (ack[0] && a0 == 0) a0 = c;
      if (rdy[0] && r0 == 0) r0 = c;
      if (r0 == 0) tick;
    end
  endtask

  task automatic lat(input string n, input int e0, input int er0, input int e1, input int er1);
    chk({n, "_ack_cyc"}, 0, a0, e0);
    chk({n, "_ready_cyc"}, 0, r0, er0);
    chk({n, "_ack_cyc"}, 1, a1, e1);
    chk({n, "_ready_cyc"}, 1, r1, er1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    tick; tick;
    Reset = 1;
    chk("reset_ready", 0, 32'(rdy[0]), 1);
    chk("reset_rdata", 0, 32'(rd[0]), 0);
    Dfm = 16'hBEEF;
    go(0, 20'h00010, 16'h0, 2'b11);
    lat("rd", 3, 5, 2, 3);
    chk("rd_beef", 0, 32'(rd[0]), 32'hBEEF);
    chk("rd_beef", 1, 32'(rd[1]), 32'hBEEF);
    go(1, 20'h0FFFF, 16'h1234, 2'b11);
    lat("wr", 5, 7, 4, 5);
    chk("wr_keeps_rdata", 0, 32'(rd[0]), 32'hBEEF);
    Dfm = 16'hA5C3;
    go(0, 20'h00123, 16'h0, 2'b01);
    lat("rd_lo", 3, 5, 2, 3);
    chk("rd_lo_mask", 0, 32'(rd[0]), 32'h00C3);
    chk("rd_lo_mask", 1, 32'(rd[1]), 32'h00C3);
    Dfm = 16'hFFFF;
    go(0, 20'hFFFFF, 16'h0, 2'b00);
    lat("null", 1, 3, 1, 2);
    chk("null_keeps_rdata", 0, 32'(rd[0]), 32'h00C3);
    Dfm = 16'h1111;
    Bmask = 2'b11; Addr = 20'h00ABC; Wdata = 16'h5A5A;
    cnt_en = 1;
    Req = 1;
    for (int c = 0; c < 20; c++) begin
      Rw = ~Rw;
      tick;
    end
    Req = 0;
    for (int c = 0; c < 40 && !rdy[0]; c++) tick;
    tick;
    cnt_en = 0;
    chk("b2b_one_ack_per_access", 0, nack, nacc);
    chk("b2b_min_accepts", 0, 32'(nacc >= 3), 1);
    Rw = 1; Addr = 20'h00200; Wdata = 16'hCAFE; Bmask = 2'b11; Req = 1;
    tick;
    Req = 0;
    tick;
    Reset = 0;
    tick;
    chk("rst_ce", 0, 32'(ce[0]), 1);
    chk("rst_we", 0, 32'(we[0]), 1);
    chk("rst_ack", 0, 32'(ack[0]), 0);
    chk("rst_rdata", 0, 32'(rd[0]), 0);
    chk("rst_ready", 0, 32'(rdy[0]), 1);
    Reset = 1;
    Dfm = 16'h1357;
    go(0, 20'h00300, 16'h0, 2'b11);
    lat("post_rst", 3, 5, 2, 3);
    chk("post_rst_rdata", 0, 32'(rd[0]), 32'h1357);
    tick;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_access_seq.md
Name: mem_access_seq

Overview:
- CPU-side initiator for the memory-mapped bus (ADDR, CE, UB, LB, OE, WE and the two data buses) that feeds the existing SRAM/IO bridge.
- Turns a single-cycle Req/Ready request from the CPU datapath into correctly sequenced active-low SRAM strobes, with programmable wait states.
- Captures read data and returns a one-cycle Ack.
- Address 16'hFFFF (switches / hex display) uses the same timing as any other address; no decode is done here.

Parameters:
READ_WAIT, 2, cycles that CE/OE/byte strobes stay asserted on a read (legal 1..15)
WRITE_WAIT, 2, cycles WE stays low on a write (legal 1..15)
TURNAROUND, 1, idle cycles with all strobes high after Ack before Ready returns (legal 0..7)

Ports:
Clk  in  1  single clock, all logic on posedge
Reset  in  1  synchronous reset, active-low
Req  in  1  request; sampled only when Ready=1
Rw  in  1  1=write, 0=read; captured with Req
Addr  in  20  word address; captured with Req
Wdata  in  16  write data; captured with Req
Bmask  in  2  byte enables, active-high: [1]=upper byte, [0]=lower byte
Ready  out  1  1 in IDLE; accepting a request
Ack  out  1  one-cycle pulse: access complete
Rdata  out  16  read data; holds until the next read Ack or reset
ADDR  out  20  to memory bus
CE, UB, LB, OE, WE  out  1 each  active-low strobes to memory bus
Data_to_mem  out  16  to bridge Data_from_CPU
Data_from_mem  in  16  from bridge Data_to_CPU

Behaviour:
- Reset state (Reset=0 at posedge), applied at that edge:
  - Outputs: Ack=0, Rdata=0, ADDR=0, Data_to_mem=0, all strobes=1.
  - FSM goes to IDLE, so Ready=1 from the first cycle after the edge.
  - Reset mid-access aborts it: strobes go high at that edge, no Ack is issued, and Rdata is cleared.
- All outputs are registered. Ready is decoded from state (IDLE only).
- States: IDLE, RD_STROBE, WR_SETUP, WR_PULSE, WR_HOLD, ACK, TURN.
- Accept: posedge E0 with Ready=1 and Req=1 latches Rw, Addr, Wdata and Bmask. Req with Ready=0 is ignored; it is not queued.
- Cycle numbering: c1 is the cycle after E0.
- Read (Rw=0):
  - RD_STROBE for c1..c(READ_WAIT): ADDR=latched, CE=0, OE=0, WE=1, UB=~Bmask[1], LB=~Bmask[0].
  - At the posedge ending the last RD_STROBE cycle, Rdata <= Data_from_mem with disabled bytes forced to 0.
  - ACK for one cycle: Ack=1, strobes high.
- Write (Rw=1):
  - WR_SETUP for 1 cycle: CE=0, OE=1, WE=1, UB/LB per mask, Data_to_mem=Wdata.
  - WR_PULSE for WRITE_WAIT cycles: same as WR_SETUP but WE=0.
  - WR_HOLD for 1 cycle: WE=1, CE, UB/LB and data still driven.
  - ACK. Rdata unchanged.
- OE and WE are never low in the same cycle. In all non-access states, strobes=1 and Data_to_mem=0.
- ADDR is 0 outside access states.
- Bmask=00 is a null access: no strobe goes low, the FSM goes directly to ACK at c1, Rdata is not updated on a read, and turnaround still applies.
- TURN lasts TURNAROUND cycles with strobes high and Ready=0, then IDLE. With TURNAROUND=0, ACK goes straight to IDLE.
- Accept-to-Ack latency:
  - read: READ_WAIT+1 cycles
  - write: WRITE_WAIT+3 cycles
  - null: 1 cycle
- Wait counter is 4 bits, loaded on state entry, counts down to 1. No wrap is possible within the legal parameter range.
- Back-to-back: Req held high is re-accepted at the first Ready=1 edge. No request is accepted during ACK or TURN.
- Rdata and Ack are not affected by changes on Addr, Wdata or Bmask after accept.

Test Plan:
- Reset release, then read Addr=20'h00010, Bmask=11, Data_from_mem=16'hBEEF (defaults) -> CE/OE low at c1-c2, WE=1 throughout, Ack in c3, Rdata=16'hBEEF, Ready=1 in c5.
- Write Addr=20'h0FFFF, Wdata=16'h1234, Bmask=11 -> c1 setup with WE=1 and data=16'h1234; WE low in c2-c3; c4 hold with WE=1 and CE=0; Ack in c5; OE=1 throughout.
- Read Bmask=01, Data_from_mem=16'hA5C3 -> UB=1, LB=0 during strobe, Rdata=16'h00C3. Then a Bmask=00 read -> no strobes, Ack in c1, Rdata stays 16'h00C3.
- Req held high for 20 cycles with alternating Rw -> each access is accepted only when Ready=1, exactly one Ack per access, OE and WE never low together.
- Reset=0 asserted in c2 of a write -> all strobes high at that edge, no Ack, Rdata=0, Ready=1 next cycle. A following read completes normally.
- Parameter sweep READ_WAIT=1/WRITE_WAIT=1/TURNAROUND=0 -> read Ack in c2, write Ack in c4, Ready=1 in the cycle immediately after Ack.
